// File: rtl/gold_miner_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : gold_miner_pkg                                                  |
// | Shared definitions for the gold-miner game control blocks: object type    |
// | codes, heavy-object threshold, object score table, screen limits and the |
// | retract FSM state encoding.                                               |
// | Revision: 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
package gold_miner_pkg;

  // Object type codes carried by the hook (0 = nothing attached).
  // Codes are ordered so that everything from HEAVY_MIN upward is heavy.
  localparam logic [4:0] OBJ_NONE        = 5'd0;
  localparam logic [4:0] OBJ_DIAMOND     = 5'd1;
  localparam logic [4:0] OBJ_GOLD_SMALL  = 5'd2;
  localparam logic [4:0] OBJ_BAG         = 5'd3;
  localparam logic [4:0] OBJ_GOLD_MED    = 5'd4;
  localparam logic [4:0] OBJ_STONE_SMALL = 5'd5;
  localparam logic [4:0] OBJ_GOLD_BIG    = 5'd6;
  localparam logic [4:0] OBJ_STONE_BIG   = 5'd7;

  // Objects at or above this code slow the retract down.
  localparam logic [4:0] HEAVY_MIN = OBJ_GOLD_BIG;

  // Screen geometry shared with the descend FSM and draw engine.
  localparam logic [7:0] SCREEN_Y_FLOOR = 8'd230;
  localparam logic [7:0] HOOK_HEIGHT    = 8'd9;

  // Retract FSM states.
  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_LATCH = 4'd1,
    S_DRAW  = 4'd2,
    S_CHECK = 4'd3,
    S_WAIT  = 4'd4,
    S_ERASE = 4'd5,
    S_STEP  = 4'd6,
    S_SCORE = 4'd7,
    S_EXIT  = 4'd8
  } pull_state_t;

  // Points awarded for a returned object. Codes without an entry score 0.
  function automatic logic [7:0] score_lut(input logic [4:0] obj);
    logic [7:0] pts;
    case (obj)
      OBJ_DIAMOND:     pts = 8'd250;
      OBJ_GOLD_SMALL:  pts = 8'd50;
      OBJ_BAG:         pts = 8'd100;
      OBJ_GOLD_MED:    pts = 8'd100;
      OBJ_STONE_SMALL: pts = 8'd10;
      OBJ_GOLD_BIG:    pts = 8'd200;
      OBJ_STONE_BIG:   pts = 8'd20;
      default:         pts = 8'd0;
    endcase
    return pts;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pull_tick_divider.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : pull_tick_divider                                               |
// | Counts pacing-timer ticks while the retract FSM waits and flags the tick  |
// | that completes a step: 1 tick for light objects, HEAVY_TICKS for heavy.   |
// | Only instantiated when WEIGHT_SLOWDOWN_EN is defined.                     |
// | Ports   : clk, resetn (sync, active-low)                                  |
// |           clear    - zero the count (new retract)                         |
// |           tick     - qualified timer tick (only while waiting)            |
// |           heavy    - carried object is heavy                              |
// |           step_due - this tick completes the step (combinational)         |
// | Revision: 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module pull_tick_divider #(
  parameter int HEAVY_TICKS = 3
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic tick,
  input  logic heavy,
  output logic step_due
);

  logic [3:0] count;
  logic [3:0] needed;

  assign needed   = heavy ? 4'(HEAVY_TICKS) : 4'd1;
  // The count holds ticks already seen in this step; the current tick is the
  // last one needed when count+1 reaches the target.
  assign step_due = tick && ((count + 4'd1) >= needed);

  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      count <= 4'd0;
    end else if (tick) begin
      count <= step_due ? 4'd0 : count + 4'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pullback_control.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : pullback_control                                                |
// | Retract FSM: walks the hook from its release point back up to HOME_Y one |
// | step per pacing step, drawing/erasing it through the shared draw engine, |
// | carrying any grabbed object, then reports that object's score.           |
// | Config  : WEIGHT_SLOWDOWN_EN - heavy objects need HEAVY_TICKS timer ticks |
// |           per step (otherwise one tick per step for every object).       |
// | Ports   : clk, resetn (sync, active-low)                                  |
// |   in  start_pullback          level request from top control             |
// |   in  current_release_x/y     hook position at end of descent            |
// |   in  reach_bottom            descent hit the floor, nothing grabbed     |
// |   in  grabbed_type            object code under the hook                 |
// |   in  draw_object_done        draw engine completion pulse               |
// |   in  enable_next_pull_state  pacing timer tick                          |
// |   out enable_counter_pull     run the pacing timer                       |
// |   out start_draw_pull_hook    draw engine request                        |
// |   out erase_pull_hook         engine paints background instead of hook   |
// |   out pull_x_start/y_start    hook position for the engine               |
// |   out carry_type              object drawn under the hook                |
// |   out score_add/score_valid   points for the returned object             |
// |   out done_pullback           retract finished                           |
// | Revision: 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module pullback_control
  import gold_miner_pkg::*;
#(
  parameter logic [7:0] HOME_Y      = 8'd40,
  parameter int         STEP_PX     = 1,
  parameter int         HEAVY_TICKS = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start_pullback,
  input  logic [8:0] current_release_x,
  input  logic [7:0] current_release_y,
  input  logic       reach_bottom,
  input  logic [4:0] grabbed_type,
  input  logic       draw_object_done,
  input  logic       enable_next_pull_state,
  output logic       enable_counter_pull,
  output logic       start_draw_pull_hook,
  output logic       erase_pull_hook,
  output logic [8:0] pull_x_start,
  output logic [7:0] pull_y_start,
  output logic [4:0] carry_type,
  output logic [7:0] score_add,
  output logic       score_valid,
  output logic       done_pullback
);

  localparam logic [8:0] STEP_W = 9'(STEP_PX);

  pull_state_t state, state_nxt;
  logic [8:0]  hook_x, x_nxt;
  logic [7:0]  hook_y, y_nxt;
  logic [4:0]  hook_type, type_nxt;
  logic [7:0]  y_stepped;
  logic        step_due;
  logic        drawing_nxt;

  // Moving up never passes HOME_Y: compare in 9 bits so HOME_Y+STEP_PX
  // cannot wrap.
  assign y_stepped = (({1'b0, hook_y}) < ({1'b0, HOME_Y} + STEP_W))
                     ? HOME_Y : (hook_y - 8'(STEP_PX));

`ifdef WEIGHT_SLOWDOWN_EN
  pull_tick_divider #(
    .HEAVY_TICKS (HEAVY_TICKS)
  ) u_tick_div (
    .clk      (clk),
    .resetn   (resetn),
    .clear    (state == S_LATCH),
    .tick     ((state == S_WAIT) && enable_next_pull_state),
    .heavy    (hook_type >= HEAVY_MIN),
    .step_due (step_due)
  );
`else
  // Every object advances on each timer tick.
  assign step_due = (state == S_WAIT) && enable_next_pull_state;
  logic [31:0] unused_heavy_ticks;
  assign unused_heavy_ticks = 32'(HEAVY_TICKS);
`endif

  // Next state and next datapath values. Outputs are registered from these
  // so they line up with the state they belong to.
  always_comb begin
    state_nxt = state;
    x_nxt     = hook_x;
    y_nxt     = hook_y;
    type_nxt  = hook_type;
    case (state)
      S_IDLE: begin
        if (start_pullback) state_nxt = S_LATCH;
      end
      S_LATCH: begin
        x_nxt     = current_release_x;
        // A release point at or above home collapses to a single draw.
        y_nxt     = (current_release_y <= HOME_Y) ? HOME_Y : current_release_y;
        type_nxt  = reach_bottom ? OBJ_NONE : grabbed_type;
        state_nxt = S_DRAW;
      end
      S_DRAW: begin
        if (draw_object_done) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        state_nxt = (hook_y == HOME_Y) ? S_SCORE : S_WAIT;
      end
      S_WAIT: begin
        if (step_due) state_nxt = S_ERASE;
      end
      S_ERASE: begin
        if (draw_object_done) state_nxt = S_STEP;
      end
      S_STEP: begin
        y_nxt     = y_stepped;
        state_nxt = S_DRAW;
      end
      S_SCORE: begin
        state_nxt = S_EXIT;
      end
      S_EXIT: begin
        if (!start_pullback) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign drawing_nxt = (state_nxt == S_DRAW) || (state_nxt == S_ERASE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state                <= S_IDLE;
      hook_x               <= 9'd0;
      hook_y               <= 8'd0;
      hook_type            <= 5'd0;
      enable_counter_pull  <= 1'b0;
      start_draw_pull_hook <= 1'b0;
      erase_pull_hook      <= 1'b0;
      pull_x_start         <= 9'd0;
      pull_y_start         <= 8'd0;
      carry_type           <= 5'd0;
      score_add            <= 8'd0;
      score_valid          <= 1'b0;
      done_pullback        <= 1'b0;
    end else begin
      state                <= state_nxt;
      hook_x               <= x_nxt;
      hook_y               <= y_nxt;
      hook_type            <= type_nxt;
      enable_counter_pull  <= (state_nxt == S_WAIT);
      start_draw_pull_hook <= drawing_nxt;
      erase_pull_hook      <= (state_nxt == S_ERASE);
      // Position and carried object are only presented while the engine is
      // busy, so the bus reads zero at all other times.
      pull_x_start         <= drawing_nxt ? x_nxt    : 9'd0;
      pull_y_start         <= drawing_nxt ? y_nxt    : 8'd0;
      carry_type           <= drawing_nxt ? type_nxt : 5'd0;
      score_valid          <= (state_nxt == S_SCORE);
      score_add            <= (state_nxt == S_SCORE) ? score_lut(type_nxt) : 8'd0;
      done_pullback        <= (state_nxt == S_EXIT);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pullback_control.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_pullback_control                                             |
// | Self-checking bench for pullback_control. Two instances (1 px and 4 px   |
// | steps) share the request inputs; each has its own emulated draw engine   |
// | and pacing timer. Observed draw/erase sequences and scores are compared  |
// | against a reference built directly from the retract rules.               |
// | Revision: 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_pullback_control;

  localparam int HOME      = 40;
  localparam int HEAVY_T   = 3;
  localparam int HEAVY_OBJ = 6;
  localparam int LIMIT     = 20000;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn;
  logic       start_pullback;
  logic [8:0] rel_x;
  logic [7:0] rel_y;
  logic       reach_bottom;
  logic [4:0] grabbed;

  logic       done_in    [2];
  logic       tick_in    [2];
  logic       en_cnt     [2];
  logic       start_draw [2];
  logic       erase      [2];
  logic [8:0] px         [2];
  logic [7:0] py         [2];
  logic [4:0] carry      [2];
  logic [7:0] score_add  [2];
  logic       score_vld  [2];
  logic       done_pb    [2];

  pullback_control #(.HOME_Y(8'd40), .STEP_PX(1), .HEAVY_TICKS(HEAVY_T)) u_dut1 (
    .clk(clk), .resetn(resetn), .start_pullback(start_pullback),
    .current_release_x(rel_x), .current_release_y(rel_y),
    .reach_bottom(reach_bottom), .grabbed_type(grabbed),
    .draw_object_done(done_in[0]), .enable_next_pull_state(tick_in[0]),
    .enable_counter_pull(en_cnt[0]), .start_draw_pull_hook(start_draw[0]),
    .erase_pull_hook(erase[0]), .pull_x_start(px[0]), .pull_y_start(py[0]),
    .carry_type(carry[0]), .score_add(score_add[0]), .score_valid(score_vld[0]),
    .done_pullback(done_pb[0]));

  pullback_control #(.HOME_Y(8'd40), .STEP_PX(4), .HEAVY_TICKS(HEAVY_T)) u_dut4 (
    .clk(clk), .resetn(resetn), .start_pullback(start_pullback),
    .current_release_x(rel_x), .current_release_y(rel_y),
    .reach_bottom(reach_bottom), .grabbed_type(grabbed),
    .draw_object_done(done_in[1]), .enable_next_pull_state(tick_in[1]),
    .enable_counter_pull(en_cnt[1]), .start_draw_pull_hook(start_draw[1]),
    .erase_pull_hook(erase[1]), .pull_x_start(px[1]), .pull_y_start(py[1]),
    .carry_type(carry[1]), .score_add(score_add[1]), .score_valid(score_vld[1]),
    .done_pullback(done_pb[1]));

  typedef struct {
    bit er;
    int x;
    int y;
    int carry;
    int ticks;
  } rec_t;

  typedef struct {
    int rx; int ry; int rb; int gt;
    int d1; int d4; int score;
  } vec_t;

  rec_t obs0[$], obs1[$], exp0[$], exp1[$];
  int   tick_since[2];
  int   wait_cnt[2];
  int   score_seen[2];
  int   score_val[2];
  int   bad_idle[2];
  bit   done_seen[2];
  bit   noise;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int k, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s[dut%0d]: got %0d expected %0d", name, k, act, expv);
    end
  endtask

  // Reference facts taken straight from the object table and retract rules.
  function automatic int score_of(input int t);
    case (t)
      1: return 250;
      2: return 50;
      3: return 100;
      4: return 100;
      5: return 10;
      6: return 200;
      7: return 20;
      default: return 0;
    endcase
  endfunction

  function automatic int ticks_for(input int t);
`ifdef WEIGHT_SLOWDOWN_EN
    return (t >= HEAVY_OBJ) ? HEAVY_T : 1;
`else
    return (t >= HEAVY_OBJ) ? 1 : 1;
`endif
  endfunction

  // Expected sequence: draw at each height from the clamped start up to HOME;
  // every draw except the last is followed by a paced erase.
  task automatic build_model(input int k, input int rx, input int ry, input int rb, input int gt);
    int t, y, step, need;
    rec_t r;
    t    = rb ? 0 : gt;
    y    = (ry < HOME) ? HOME : ry;
    step = (k == 0) ? 1 : 4;
    need = ticks_for(t);
    while (1) begin
      r = '{er: 1'b0, x: rx, y: y, carry: t, ticks: 0};
      if (k == 0) exp0.push_back(r); else exp1.push_back(r);
      if (y == HOME) break;
      r = '{er: 1'b1, x: rx, y: y, carry: t, ticks: need};
      if (k == 0) exp0.push_back(r); else exp1.push_back(r);
      y = (y - step < HOME) ? HOME : y - step;
    end
  endtask

  // Draw-engine / pacing-timer emulation and output monitor, one pass per
  // negative edge for both instances.
  initial begin
    for (int k = 0; k < 2; k++) begin
      done_in[k] = 1'b0; tick_in[k] = 1'b0; wait_cnt[k] = 0; tick_since[k] = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!resetn) begin
          done_in[k] = 1'b0; tick_in[k] = 1'b0; tick_since[k] = 0;
        end else begin
          if (score_vld[k]) begin score_seen[k]++; score_val[k] = int'(score_add[k]); end
          if (done_pb[k]) done_seen[k] = 1'b1;
          if (!start_draw[k] && (px[k] != 0 || py[k] != 0 || carry[k] != 0 || erase[k])) bad_idle[k]++;
          if (start_draw[k] && int'(py[k]) < HOME) bad_idle[k]++;
          if (!score_vld[k] && score_add[k] != 0) bad_idle[k]++;
          if (done_in[k]) begin
            done_in[k] = 1'b0;
          end else if (start_draw[k]) begin
            if (wait_cnt[k] == 0) begin
              rec_t r;
              r = '{er: erase[k], x: int'(px[k]), y: int'(py[k]), carry: int'(carry[k]),
                    ticks: tick_since[k]};
              if (k == 0) obs0.push_back(r); else obs1.push_back(r);
              tick_since[k] = 0;
              done_in[k]    = 1'b1;
              wait_cnt[k]   = $urandom_range(0, 3);
            end else begin
              wait_cnt[k]--;
            end
          end else if (noise && $urandom_range(0, 3) == 0) begin
            done_in[k] = 1'b1;
          end
          if (tick_in[k]) begin
            tick_in[k] = 1'b0;
          end else if (en_cnt[k]) begin
            if ($urandom_range(0, 1) == 1) begin tick_in[k] = 1'b1; tick_since[k]++; end
          end else if (noise && $urandom_range(0, 3) == 0) begin
            tick_in[k] = 1'b1;
          end
        end
      end
    end
  end

  task automatic clear_obs();
    obs0.delete(); obs1.delete(); exp0.delete(); exp1.delete();
    for (int k = 0; k < 2; k++) begin
      score_seen[k] = 0; score_val[k] = -1; bad_idle[k] = 0; done_seen[k] = 1'b0;
      tick_since[k] = 0;
    end
  endtask

  task automatic cmp_seq(input int k, input string tag, input int exp_draws);
    rec_t o[$], e[$];
    int   ndraw, bad;
    if (k == 0) begin o = obs0; e = exp0; end else begin o = obs1; e = exp1; end
    ndraw = 0;
    foreach (o[i]) if (!o[i].er) ndraw++;
    if (exp_draws >= 0) check({tag, "_draw_count"}, k, ndraw, exp_draws);
    check({tag, "_seq_len"}, k, o.size(), e.size());
    bad = -1;
    if (o.size() == e.size()) begin
      foreach (o[i]) begin
        if (bad < 0 && (o[i].er != e[i].er || o[i].x != e[i].x || o[i].y != e[i].y ||
                        o[i].ticks != e[i].ticks || (!o[i].er && o[i].carry != e[i].carry)))
          bad = i;
      end
      if (bad >= 0)
        $display("  first difference at %0d: er=%0d x=%0d y=%0d carry=%0d ticks=%0d vs er=%0d x=%0d y=%0d carry=%0d ticks=%0d",
                 bad, o[bad].er, o[bad].x, o[bad].y, o[bad].carry, o[bad].ticks,
                 e[bad].er, e[bad].x, e[bad].y, e[bad].carry, e[bad].ticks);
      check({tag, "_seq_first_bad_index"}, k, bad, -1);
    end
  endtask

  task automatic run_retract(input string tag, input int rx, input int ry, input int rb,
                             input int gt, input bit drop_early,
                             input int d1, input int d4, input int exp_score);
    int cyc;
    clear_obs();
    build_model(0, rx, ry, rb, gt);
    build_model(1, rx, ry, rb, gt);
    @(negedge clk); #1;
    rel_x = 9'(rx); rel_y = 8'(ry); reach_bottom = 1'(rb); grabbed = 5'(gt);
    start_pullback = 1'b1;
    cyc = 0;
    repeat (3) begin @(negedge clk); #1; cyc++; end
    // Release inputs are latched; later changes must have no effect.
    rel_x = 9'($urandom); rel_y = 8'($urandom); reach_bottom = 1'($urandom); grabbed = 5'($urandom);
    if (drop_early) start_pullback = 1'b0;
    while (!(done_seen[0] && done_seen[1]) && cyc < LIMIT) begin
      @(negedge clk); #1; cyc++;
    end
    check({tag, "_finished_in_budget"}, 0, (cyc < LIMIT) ? 1 : 0, 1);
    if (!drop_early) begin
      repeat (3) begin @(negedge clk); #1; end
      for (int k = 0; k < 2; k++) check({tag, "_done_held"}, k, done_pb[k], 1);
      start_pullback = 1'b0;
    end
    repeat (3) begin @(negedge clk); #1; end
    for (int k = 0; k < 2; k++) begin
      check({tag, "_done_released"}, k, done_pb[k], 0);
      check({tag, "_score_pulses"}, k, score_seen[k], 1);
      check({tag, "_score_value"}, k, score_val[k], exp_score);
      check({tag, "_idle_bus_violations"}, k, bad_idle[k], 0);
      cmp_seq(k, tag, (k == 0) ? d1 : d4);
    end
  endtask

  vec_t tbl[9];

  initial begin
    tbl[0] = '{rx: 100, ry: 100, rb: 1, gt: 0,  d1: 61, d4: 16, score: 0};
    tbl[1] = '{rx: 200, ry: 45,  rb: 0, gt: 2,  d1: 6,  d4: 3,  score: 50};
    tbl[2] = '{rx: 17,  ry: 30,  rb: 0, gt: 1,  d1: 1,  d4: 1,  score: 250};
    tbl[3] = '{rx: 300, ry: 50,  rb: 0, gt: 7,  d1: 11, d4: 4,  score: 20};
    tbl[4] = '{rx: 5,   ry: 42,  rb: 0, gt: 20, d1: 3,  d4: 2,  score: 0};
    tbl[5] = '{rx: 511, ry: 40,  rb: 0, gt: 3,  d1: 1,  d4: 1,  score: 100};
    tbl[6] = '{rx: 60,  ry: 120, rb: 1, gt: 6,  d1: 81, d4: 21, score: 0};
    tbl[7] = '{rx: 250, ry: 45,  rb: 0, gt: 6,  d1: 6,  d4: 3,  score: 200};
    tbl[8] = '{rx: 0,   ry: 44,  rb: 0, gt: 5,  d1: 5,  d4: 2,  score: 10};

    resetn = 1'b0; start_pullback = 1'b0; rel_x = '0; rel_y = '0;
    reach_bottom = 1'b0; grabbed = '0; noise = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check("reset_outputs", k,
            {en_cnt[k], start_draw[k], erase[k], px[k], py[k], carry[k],
             score_add[k], score_vld[k], done_pb[k]}, 0);
    end
    resetn = 1'b1;

    for (int i = 0; i < 9; i++) begin
      noise = (i != 0);
      run_retract($sformatf("vec%0d", i), tbl[i].rx, tbl[i].ry, tbl[i].rb, tbl[i].gt,
                  1'b0, tbl[i].d1, tbl[i].d4, tbl[i].score);
    end

    for (int i = 0; i < 10; i++) begin
      int rx, ry, rb, gt;
      rx = $urandom_range(0, 511); ry = $urandom_range(0, 110);
      rb = $urandom_range(0, 1);   gt = $urandom_range(0, 31);
      noise = 1'b1;
      run_retract($sformatf("rand%0d", i), rx, ry, rb, gt, 1'($urandom_range(0, 1)),
                  -1, -1, score_of(rb ? 0 : gt));
    end

    // Reset while waiting for the pacing timer aborts without a score.
    begin
      int cyc;
      clear_obs();
      noise = 1'b0;
      @(negedge clk); #1;
      rel_x = 9'd123; rel_y = 8'd80; reach_bottom = 1'b0; grabbed = 5'd2;
      start_pullback = 1'b1;
      cyc = 0;
      while (!en_cnt[0] && cyc < 200) begin @(negedge clk); #1; cyc++; end
      check("abort_reached_wait", 0, en_cnt[0], 1);
      resetn = 1'b0; start_pullback = 1'b0;
      @(negedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        check("abort_outputs_zero", k,
              {en_cnt[k], start_draw[k], erase[k], px[k], py[k], carry[k],
               score_add[k], score_vld[k], done_pb[k]}, 0);
      end
      resetn = 1'b1;
      repeat (10) begin @(negedge clk); #1; end
      for (int k = 0; k < 2; k++) begin
        check("abort_no_score", k, score_seen[k], 0);
        check("abort_stays_idle", k, {start_draw[k], en_cnt[k], done_pb[k]}, 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
